somador_sequencial_32b: RTL and testbench
=========================================

SOMADOR_SEQUENCIAL_32B -- requirements
Module: somador_sequencial_32b

Interface
REQ-001 The block SHALL have parameter N_BYTES, default 4, giving the operand width in bytes (operand width W = 8*N_BYTES).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled on rising clk.
REQ-006 A  input  W  first operand; sampled only when start is accepted.
REQ-007 B  input  W  second operand; sampled only when start is accepted.
REQ-008 sub  input  1  operation select, 1 = A-B (present only with SOMA_SUB_EN).
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking a valid result.
REQ-011 S  output  W  result, registered.
REQ-012 Cout  output  1  final carry out of the most significant byte.
REQ-013 V  output  1  signed overflow of the W-bit result.

Function
REQ-014 The block SHALL contain exactly one 8-bit full-adder slice (ripple of eight 1-bit full adders, carry-in from a carry register) and reuse it once per byte.
REQ-015 The FSM SHALL have states IDLE, ADD and DONE; busy = 1 exactly in ADD.
REQ-016 IDLE/DONE to ADD: when start = 1, latch A and B, clear byte index to 0, load carry register with 0 (with 1 for subtract), and clear S.
REQ-017 ADD: each cycle, add byte[idx] of A and B (or ~B) with the carry register, write the byte sum into S[8*idx+7:8*idx], store the slice carry-out, and increment idx.
REQ-018 ADD to DONE: after the byte with idx = N_BYTES-1 is processed; Cout takes the final carry and V = (Amsb == Beff_msb) && (Smsb != Amsb).
REQ-019 DONE: done = 1 for exactly one cycle; without start the next state is IDLE.
REQ-020 Latency: start accepted on edge T gives done high in cycle T+N_BYTES+1 (T+5 for the default).
REQ-021 start while busy = 1 SHALL be ignored; latched operands and progress SHALL be unaffected.
REQ-022 start in the DONE cycle SHALL be accepted (back-to-back), with done still pulsing that cycle.
REQ-023 S, Cout and V SHALL hold their last values from DONE until the next accepted start.
REQ-024 Arithmetic SHALL be modulo 2^W; Cout = 1 on unsigned add overflow; for subtract, Cout = 1 means no borrow (A >= B unsigned).
REQ-025 A and B changing during ADD SHALL NOT affect the result.

Reset
REQ-026 When rst_n = 0, at any time including mid-operation, the block SHALL asynchronously force state IDLE, idx = 0, carry = 0, S = 0, Cout = 0, V = 0, busy = 0 and done = 0.
REQ-027 An aborted operation SHALL produce no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-028 Macro SOMA_SUB_EN: when defined, the sub port exists, is latched with the operands, and selects B inversion with carry-in 1.
REQ-029 Without SOMA_SUB_EN, the sub port is absent and the block SHALL always add with carry-in 0.

Verification
REQ-030 A=0xFFFFFFFF, B=0x00000001, start at T -> done at T+5, S=0x00000000, Cout=1, V=0, busy high in cycles T+1..T+4.
REQ-031 A=0x7FFFFFFF, B=0x00000001 -> S=0x80000000, Cout=0, V=1.
REQ-032 start at T with A=0x12345678, B=0x11111111, then start again at T+2 with other operands -> a single done at T+5 with S=0x23456789; the second start is ignored.
REQ-033 Pulse rst_n low at T+2 during an operation -> all outputs 0 immediately and no done pulse; a new start with A=3, B=4 -> S=7.
REQ-034 start held high through the DONE cycle -> done pulses and a second operation begins in the same cycle, with its done 5 cycles later.
REQ-035 With SOMA_SUB_EN: sub=1, A=5, B=7 -> S=0xFFFFFFFE, Cout=0, V=0; sub=1, A=0x80000000, B=1 -> S=0x7FFFFFFF, V=1, Cout=1.

Source files
------------

// File: rtl/somador_sequencial_32b.sv
// -----------------------------------------------------------------------------
// somador_sequencial_32b
//
// Byte-serial adder/subtractor. A single 8-bit ripple-carry slice is reused
// once per byte, so a W-bit operation (W = 8*N_BYTES) takes N_BYTES cycles in
// ADD followed by one DONE cycle.
//
// Configuration macro:
//   SOMA_SUB_EN  - when defined, adds the 'sub' port (1 = A-B). Without it the
//                  block always computes A+B with carry-in 0.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  begin an operation (accepted in IDLE or DONE)
//   A, B   in   W  operands, captured when start is accepted
//   sub    in   1  operation select, 1 = A-B (only with SOMA_SUB_EN)
//   busy   out  1  high while bytes are being processed (ADD)
//   done   out  1  one-cycle pulse, result valid
//   S      out  W  registered result
//   Cout   out  1  carry out of the top byte (no-borrow for subtract)
//   V      out  1  signed overflow of the W-bit result
// -----------------------------------------------------------------------------
module somador_sequencial_32b #(
    parameter int N_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [8*N_BYTES-1:0] A,
    input  logic [8*N_BYTES-1:0] B,
`ifdef SOMA_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [8*N_BYTES-1:0] S,
    output logic                 Cout,
    output logic                 V
);

    localparam int W     = 8 * N_BYTES;
    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sub_q, sub_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     s_q, s_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    // Operation select seen at the input; tied to add when subtract is not built.
    logic sub_in;
`ifdef SOMA_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // The one shared 8-bit slice: eight chained 1-bit full adders.
    // Subtraction is A + ~B + 1; the +1 comes from the carry register.
    // -------------------------------------------------------------------------
    logic [7:0] a_byte;
    logic [7:0] b_eff_byte;
    logic [7:0] sum_byte;
    logic       ripple_c;
    logic       slice_cout;

    always_comb begin
        a_byte     = a_q[8*idx_q +: 8];
        b_eff_byte = b_q[8*idx_q +: 8] ^ {8{sub_q}};
        sum_byte   = '0;
        ripple_c   = carry_q;
        for (int i = 0; i < 8; i++) begin
            sum_byte[i] = a_byte[i] ^ b_eff_byte[i] ^ ripple_c;
            ripple_c    = (a_byte[i] & b_eff_byte[i]) |
                          (ripple_c & (a_byte[i] ^ b_eff_byte[i]));
        end
        slice_cout = ripple_c;
    end

    // Sign bit of the effective second operand, used for overflow detection.
    logic b_eff_msb;
    assign b_eff_msb = b_q[W-1] ^ sub_q;

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ADD;
                    a_d     = A;
                    b_d     = B;
                    sub_d   = sub_in;
                    idx_d   = '0;
                    carry_d = sub_in;
                    s_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ADD: begin
                // start is deliberately not looked at here: a request while
                // busy is dropped and the operation in flight is untouched.
                s_d[8*idx_q +: 8] = sum_byte;
                carry_d           = slice_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    v_d     = (a_q[W-1] == b_eff_msb) && (sum_byte[7] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all state, so every flop samples the
    // values from before this edge regardless of statement order.
    // NOTE: the operand and result registers are reset too; an abort must
    // leave S/Cout/V at zero and no stale operands behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign busy = (state_q == ST_ADD);
    assign done = (state_q == ST_DONE);
    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;

endmodule

// File: tb/tb_somador_sequencial_32b.sv
// -----------------------------------------------------------------------------
// tb_somador_sequencial_32b
//
// Self-checking bench for somador_sequencial_32b. Inputs are driven and
// outputs sampled on the falling clock edge. Expected results come from a
// whole-word arithmetic model (W+1 bit sum, or subtract with unsigned compare).
// Subtract scenarios are built only when SOMA_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_somador_sequencial_32b;

    localparam int N_BYTES = 4;
    localparam int W       = 8 * N_BYTES;
    localparam int LAT     = N_BYTES + 1;
    // busy expected in cycles 1..N_BYTES after the accepting edge
    localparam logic [31:0] BUSY_MASK = ((32'd1 << (N_BYTES + 1)) - 32'd1) & ~32'd1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         sub_i = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    somador_sequencial_32b #(.N_BYTES(N_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
`ifdef SOMA_SUB_EN
        .sub   (sub_i),
`endif
        .busy  (busy),
        .done  (done),
        .S     (s),
        .Cout  (cout),
        .V     (v)
    );

    // Whole-word reference: modulo-2^W result, unsigned carry / no-borrow,
    // and signed overflow from operand and result signs.
    task automatic ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic op, output logic [W-1:0] s_e,
                             output logic c_e, output logic v_e);
        logic [W:0] wide;
        if (!op) begin
            wide = {1'b0, x} + {1'b0, y};
            s_e  = wide[W-1:0];
            c_e  = wide[W];
            v_e  = (x[W-1] == y[W-1]) && (s_e[W-1] != x[W-1]);
        end else begin
            s_e = x - y;
            c_e = (x >= y);
            v_e = (x[W-1] != y[W-1]) && (s_e[W-1] != x[W-1]);
        end
    endtask

    // Issues one operation and waits (bounded) for done. Returns the cycle of
    // done relative to the accepting edge (-1 on timeout) and the busy trace.
    // Operands are scrambled right after acceptance; they must not matter.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                         output int lat, output logic [31:0] busy_seen);
        @(negedge clk);
        a     = x;
        b     = y;
        sub_i = op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat       = -1;
        busy_seen = '0;
        for (int k = 1; k <= 20; k++) begin
            busy_seen[k] = busy;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        sub_i = op;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (s !== '0)       begin errors++; $display("FAIL reset_S: got %h expected 0", s); end
        checks++; if (cout !== 1'b0)  begin errors++; $display("FAIL reset_Cout: got %b expected 0", cout); end
        checks++; if (v !== 1'b0)     begin errors++; $display("FAIL reset_V: got %b expected 0", v); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb_ [6];
        logic [W-1:0] ts [6];
        logic         tc [6];
        logic         tv [6];
        int           lat;
        logic [31:0]  bseen;
        ta  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_00FF};
        tb_ = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        ts  = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0100};
        tc  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb_[i], 1'b0, lat, bseen);
            checks++; if (lat != LAT) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, LAT); end
            checks++; if (bseen !== BUSY_MASK) begin errors++; $display("FAIL vec%0d_busy: got %h expected %h", i, bseen, BUSY_MASK); end
            checks++; if (s !== ts[i]) begin errors++; $display("FAIL vec%0d_S: got %h expected %h", i, s, ts[i]); end
            checks++; if (cout !== tc[i]) begin errors++; $display("FAIL vec%0d_Cout: got %b expected %b", i, cout, tc[i]); end
            checks++; if (v !== tv[i]) begin errors++; $display("FAIL vec%0d_V: got %b expected %b", i, v, tv[i]); end
        end
        // Results hold after DONE while idle.
        repeat (3) @(negedge clk);
        checks++; if (s !== ts[5]) begin errors++; $display("FAIL hold_S: got %h expected %h", s, ts[5]); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold_idle: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, s_e;
        logic         op, c_e, v_e;
        int           lat;
        logic [31:0]  bseen;
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
`ifdef SOMA_SUB_EN
            op = 1'($urandom_range(0, 1));
`else
            op = 1'b0;
`endif
            ref_model(x, y, op, s_e, c_e, v_e);
            do_op(x, y, op, lat, bseen);
            checks++; if (lat != LAT) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, LAT); end
            checks++; if (s !== s_e || cout !== c_e || v !== v_e) begin
                errors++;
                $display("FAIL rnd%0d_result: A=%h B=%h sub=%b got S=%h C=%b V=%b expected S=%h C=%b V=%b",
                         i, x, y, op, s, cout, v, s_e, c_e, v_e);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0]  done_seen;
        logic [W-1:0] s_at5;
        done_seen = '0;
        s_at5     = '0;
        @(negedge clk);
        a     = 32'h1234_5678;
        b     = 32'h1111_1111;
        sub_i = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            done_seen[k] = done;
            if (k == 5) s_at5 = s;
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                start = 1'b1;
                a     = 32'hAAAA_AAAA;
                b     = 32'h5555_5555;
            end
            if (k == 3) start = 1'b0;
        end
        checks++; if (done_seen !== 32'h20) begin errors++; $display("FAIL ignore_done_trace: got %h expected %h", done_seen, 32'h20); end
        checks++; if (s_at5 !== 32'h2345_6789) begin errors++; $display("FAIL ignore_S: got %h expected %h", s_at5, 32'h2345_6789); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int          dones;
        int          lat;
        logic [31:0] bseen;
        dones = 0;
        @(negedge clk);
        a     = 32'h1234_5678;
        b     = 32'h1111_1111;
        sub_i = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (s !== '0 || cout !== 1'b0 || v !== 1'b0) begin errors++; $display("FAIL abort_outputs: got S=%h C=%b V=%b expected 0 0 0", s, cout, v); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
        do_op(32'd3, 32'd4, 1'b0, lat, bseen);
        checks++; if (lat != LAT) begin errors++; $display("FAIL abort_restart_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (s !== 32'd7) begin errors++; $display("FAIL abort_restart_S: got %h expected %h", s, 32'd7); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x1, y1, x2, y2, e1, e2;
        logic         c1, v1, c2, v2;
        logic [31:0]  done_seen;
        logic         busy6;
        logic [W-1:0] s5, s10;
        logic         c10, v10;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = $urandom;
        ref_model(x1, y1, 1'b0, e1, c1, v1);
        ref_model(x2, y2, 1'b0, e2, c2, v2);
        done_seen = '0;
        busy6 = 1'b0; s5 = '0; s10 = '0; c10 = 1'b0; v10 = 1'b0;
        @(negedge clk);
        a     = x1;
        b     = y1;
        sub_i = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            done_seen[k] = done;
            if (k == 1) begin a = x2; b = y2; end
            if (k == 5) s5 = s;
            if (k == 6) begin busy6 = busy; start = 1'b0; a = '0; b = '0; end
            if (k == 10) begin s10 = s; c10 = cout; v10 = v; end
        end
        checks++; if (done_seen !== 32'h420) begin errors++; $display("FAIL b2b_done_trace: got %h expected %h", done_seen, 32'h420); end
        checks++; if (s5 !== e1) begin errors++; $display("FAIL b2b_first_S: got %h expected %h", s5, e1); end
        checks++; if (busy6 !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b expected 1", busy6); end
        checks++; if (s10 !== e2 || c10 !== c2 || v10 !== v2) begin
            errors++;
            $display("FAIL b2b_second_result: got S=%h C=%b V=%b expected S=%h C=%b V=%b", s10, c10, v10, e2, c2, v2);
        end
    endtask

`ifdef SOMA_SUB_EN
    task automatic test_sub();
        int          lat;
        logic [31:0] bseen;
        do_op(32'd5, 32'd7, 1'b1, lat, bseen);
        checks++; if (s !== 32'hFFFF_FFFE || cout !== 1'b0 || v !== 1'b0) begin
            errors++; $display("FAIL sub_5_7: got S=%h C=%b V=%b expected S=fffffffe C=0 V=0", s, cout, v);
        end
        do_op(32'h8000_0000, 32'd1, 1'b1, lat, bseen);
        checks++; if (s !== 32'h7FFF_FFFF || cout !== 1'b1 || v !== 1'b1) begin
            errors++; $display("FAIL sub_min_1: got S=%h C=%b V=%b expected S=7fffffff C=1 V=1", s, cout, v);
        end
        checks++; if (lat != LAT) begin errors++; $display("FAIL sub_latency: got %0d expected %0d", lat, LAT); end
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
`ifdef SOMA_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
